motor_trigger_monitor: RTL

- Receive end of the motor PID trigger. Consumes the periodic motor trigger pulse (128/256/512/1024 Hz at 100 MHz clk) and qualifies it against the selected motor close frequency.
- Emits a one-cycle PID sample strobe, the measured trigger period, a lock flag, and early/missing-trigger error counters for status readback.
- Sits between the trigger generator and the motor PID/ADC sample logic.

---
 rtl/motor_trigger_monitor_pkg.sv | 33 +++
 rtl/motor_trigger_monitor_cnt.sv | 44 ++++
 rtl/motor_trigger_monitor.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/motor_trigger_monitor_pkg.sv
// Shared constants for the motor trigger monitor: frequency codes, expected
// trigger periods at 100 MHz, code-to-period lookup and FSM state encoding.
package motor_trig_pkg;

  localparam logic [3:0] FREQ_128HZ  = 4'd0;
  localparam logic [3:0] FREQ_256HZ  = 4'd1;
  localparam logic [3:0] FREQ_512HZ  = 4'd2;
  localparam logic [3:0] FREQ_1024HZ = 4'd3;

  localparam logic [31:0] PER_128HZ  = 32'd781250;
  localparam logic [31:0] PER_256HZ  = 32'd390625;
  localparam logic [31:0] PER_512HZ  = 32'd195312;
  localparam logic [31:0] PER_1024HZ = 32'd97656;

  // Unlisted codes fall back to the slowest rate.
  function automatic logic [31:0] period_for_code(input logic [3:0] code);
    case (code)
      FREQ_128HZ:  return PER_128HZ;
      FREQ_256HZ:  return PER_256HZ;
      FREQ_512HZ:  return PER_512HZ;
      FREQ_1024HZ: return PER_1024HZ;
      default:     return PER_128HZ;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } trig_state_t;

endpackage

// File: rtl/motor_trigger_monitor_cnt.sv
// Trigger rising-edge detect plus elapsed-cycle counter since the last
// accepted edge, with timeout compare and saturation.
module trig_interval_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        trig_i,
  input  logic        restart_i,
  input  logic        arm_i,
  input  logic [31:0] limit_i,
  output logic        edge_o,
  output logic [31:0] elapsed_o,
  output logic        timeout_o
);

  logic        trig_q;
  logic [31:0] cnt_q, cnt_d;

  assign edge_o    = trig_i & ~trig_q;
  assign elapsed_o = cnt_q;
  assign timeout_o = arm_i & (cnt_q == limit_i);

  // Counter reads 1 the cycle after a restart, so at the next edge it equals
  // the edge-to-edge distance. A timeout parks it at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i)
      cnt_d = 32'd1;
    else if (timeout_o)
      cnt_d = '1;
    else if (cnt_q != '1)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      trig_q <= trig_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/motor_trigger_monitor.sv
// Motor PID trigger monitor: qualifies trigger edges against the selected
// rate, tracks lock and counts early/missing triggers. Define
// TRIG_PERIOD_STAT_EN to enable min/max period statistics.
module motor_trigger_monitor
  import motor_trig_pkg::*;
#(
  parameter real         TCQ      = 0.1,
  parameter int unsigned TOL_CYC  = 64,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        monitor_en_i,
  input  logic [3:0]  motor_freq_i,
  input  logic        motor_trigger_i,
  input  logic        clr_i,
  output logic        motor_sample_o,
  output logic [31:0] trig_period_o,
  output logic        trig_period_vld_o,
  output logic        trig_lock_o,
  output logic        trig_err_o,
  output logic [15:0] trig_early_cnt_o,
  output logic [15:0] trig_miss_cnt_o,
  output logic [31:0] trig_period_min_o,
  output logic [31:0] trig_period_max_o
);

  // TCQ stays as an accepted override; registers here carry no delay.
  if (TCQ < 0.0) begin : g_tcq_negative
  end

  trig_state_t state_q, state_d;
  logic [3:0]  freq_q;
  logic [7:0]  run_q, run_d, run_inc;
  logic        smp_q, smp_d, vld_q, vld_d, err_q, err_d;
  logic [31:0] period_q, period_d;
  logic [15:0] early_q, early_d, miss_q, miss_d;
  logic        early_inc, miss_inc, restart;
  logic        trig_edge, timeout, armed, freq_chg, is_early;
  logic [31:0] elapsed, exp_per, lo_lim, tmo_lim;

  assign exp_per  = period_for_code(freq_q);
  assign lo_lim   = exp_per - 32'(TOL_CYC);
  assign tmo_lim  = exp_per + 32'(TOL_CYC) + 32'd1;
  assign is_early = elapsed < lo_lim;
  assign freq_chg = motor_freq_i != freq_q;
  assign armed    = (state_q == ST_TRACK) || (state_q == ST_LOCKED);
  assign run_inc  = run_q + 8'd1;

  trig_interval_counter u_interval (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .trig_i    (motor_trigger_i),
    .restart_i (restart),
    .arm_i     (armed),
    .limit_i   (tmo_lim),
    .edge_o    (trig_edge),
    .elapsed_o (elapsed),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    smp_d     = 1'b0;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    period_d  = period_q;
    early_inc = 1'b0;
    miss_inc  = 1'b0;
    restart   = 1'b0;
    if (!monitor_en_i) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_HUNT;
    end else begin
      smp_d = trig_edge;
      // A rate change discards the measurement even if an edge coincides.
      if (freq_chg) begin
        state_d = ST_HUNT;
      end else begin
        case (state_q)
          ST_HUNT: begin
            if (trig_edge) begin
              restart = 1'b1;
              run_d   = '0;
              state_d = ST_TRACK;
            end
          end
          ST_TRACK, ST_LOCKED: begin
            if (timeout) begin
              miss_inc = 1'b1;
              err_d    = 1'b1;
              state_d  = ST_HUNT;
            end else if (trig_edge) begin
              restart  = 1'b1;
              vld_d    = 1'b1;
              period_d = elapsed;
              if (is_early) begin
                early_inc = 1'b1;
                err_d     = 1'b1;
                run_d     = '0;
                state_d   = ST_TRACK;
              end else if (state_q == ST_TRACK) begin
                run_d = run_inc;
                if (32'(run_inc) >= LOCK_CNT)
                  state_d = ST_LOCKED;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    early_d = early_q;
    miss_d  = miss_q;
    if (clr_i) begin
      early_d = '0;
      miss_d  = '0;
    end else begin
      if (early_inc && early_q != '1) early_d = early_q + 16'd1;
      if (miss_inc && miss_q != '1)   miss_d  = miss_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      freq_q   <= '0;
      run_q    <= '0;
      smp_q    <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      period_q <= '0;
      early_q  <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      freq_q   <= motor_freq_i;
      run_q    <= run_d;
      smp_q    <= smp_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      period_q <= period_d;
      early_q  <= early_d;
      miss_q   <= miss_d;
    end
  end

  assign motor_sample_o    = smp_q;
  assign trig_period_o     = period_q;
  assign trig_period_vld_o = vld_q;
  assign trig_lock_o       = (state_q == ST_LOCKED);
  assign trig_err_o        = err_q;
  assign trig_early_cnt_o  = early_q;
  assign trig_miss_cnt_o   = miss_q;

`ifdef TRIG_PERIOD_STAT_EN
  logic        seen_q, seen_d;
  logic [31:0] min_q, min_d, max_q, max_d;

  always_comb begin
    seen_d = seen_q;
    min_d  = min_q;
    max_d  = max_q;
    if (clr_i) begin
      seen_d = 1'b0;
      min_d  = '1;
      max_d  = '0;
    end else if (vld_d) begin
      seen_d = 1'b1;
      if (elapsed < min_q) min_d = elapsed;
      if (elapsed > max_q) max_d = elapsed;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seen_q <= 1'b0;
      min_q  <= '1;
      max_q  <= '0;
    end else begin
      seen_q <= seen_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  // Outputs read zero until the first valid sample after reset or clear.
  assign trig_period_min_o = seen_q ? min_q : '0;
  assign trig_period_max_o = seen_q ? max_q : '0;
`else
  assign trig_period_min_o = '0;
  assign trig_period_max_o = '0;
`endif

endmodule
